// File: rtl/softmax_argmax_reader_pkg.sv
// Shared definitions for the softmax argmax reader.
//
// The global sizing macros describe the output layer of the network:
//   SOFTMAX_NODES           - number of layer-2 sums that are scanned
//   LAYER_2_OUT_BIT_WIDTH   - width of one signed layer-2 sum
//   SOFTMAX_CLASS_BIT_WIDTH - width of a class index, max(1, clog2(nodes))
//
// The package re-exports these as localparams so that parameter defaults do
// not depend on macro visibility in other files. It also holds the FSM state
// encoding of the reader.

`ifndef GLOBAL_VARIABLES_V
`define GLOBAL_VARIABLES_V
`define SOFTMAX_NODES 4
`define LAYER_2_OUT_BIT_WIDTH 6
`define SOFTMAX_CLASS_BIT_WIDTH 2
`endif

package softmax_argmax_reader_pkg;

    localparam int DEF_NODES       = `SOFTMAX_NODES;
    localparam int DEF_WIDTH       = `LAYER_2_OUT_BIT_WIDTH;
    localparam int DEF_CLASS_WIDTH = `SOFTMAX_CLASS_BIT_WIDTH;

    // IDLE waits for a vector, SCAN walks the captured copy one node per
    // cycle, HOLD presents the result until the consumer takes it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/softmax_argmax_reader.sv
// softmax_argmax_reader
//
// Finds the index and value of the largest signed sum produced by the
// layer-2 multiply-accumulate store. The whole vector is copied into a
// shadow register on capture, so the producer may change sumsIn freely while
// the scan runs. One node is compared per cycle; ties keep the lower index.
//
// Ports
//   clk          - single clock, rising edge
//   clr          - synchronous active-high reset
//   sumsIn       - NODES packed two's complement sums, node i at [i*WIDTH +: WIDTH]
//   sumsValid    - sumsIn complete and stable this cycle
//   sumsReady    - high in IDLE, a capture happens when this and sumsValid are high
//   classOut     - index of the largest sum
//   maxValueOut  - value of the largest sum
//   resultValid  - high in HOLD, classOut/maxValueOut hold the new result
//   resultReady  - consumer accepts the result, returns the block to IDLE
//   busy         - high while scanning or holding a result

module softmax_argmax_reader
    import softmax_argmax_reader_pkg::*;
#(
    parameter int NODES       = DEF_NODES,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CLASS_WIDTH = DEF_CLASS_WIDTH
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [NODES*WIDTH-1:0]   sumsIn,
    input  logic                     sumsValid,
    output logic                     sumsReady,
    output logic [CLASS_WIDTH-1:0]   classOut,
    output logic [WIDTH-1:0]         maxValueOut,
    output logic                     resultValid,
    input  logic                     resultReady,
    output logic                     busy
);

    state_e state_q, state_d;

    logic [NODES*WIDTH-1:0] shadow_q, shadow_d;
    logic [CLASS_WIDTH-1:0] scan_idx_q, scan_idx_d;
    logic [CLASS_WIDTH-1:0] best_idx_q, best_idx_d;
    logic [WIDTH-1:0]       best_val_q, best_val_d;
    logic [CLASS_WIDTH-1:0] class_q, class_d;
    logic [WIDTH-1:0]       max_q, max_d;

    logic [WIDTH-1:0]       scan_node;
    logic                   scan_last;
    logic                   scan_wins;

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; clr wipes the captured vector and the visible result.
    always_ff @(posedge clk) begin
        if (clr) begin
            shadow_q   <= '0;
            scan_idx_q <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            class_q    <= '0;
            max_q      <= '0;
        end else begin
            shadow_q   <= shadow_d;
            scan_idx_q <= scan_idx_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            class_q    <= class_d;
            max_q      <= max_d;
        end
    end

    // Node under evaluation and the signed comparator. Strictly greater is
    // required to replace the running best, which keeps the lower index on ties.
    always_comb begin
        scan_node = shadow_q[int'(scan_idx_q)*WIDTH +: WIDTH];
        scan_last = (int'(scan_idx_q) == NODES - 1);
        scan_wins = ($signed(scan_node) > $signed(best_val_q));
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sumsValid) begin
                    state_d = (NODES == 1) ? ST_HOLD : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_last) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (resultReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values. The running best lives in best_*; the visible
    // result registers are only written when the scan finishes, so the
    // previous result stays on the outputs through IDLE and a new capture.
    always_comb begin
        shadow_d   = shadow_q;
        scan_idx_d = scan_idx_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        class_d    = class_q;
        max_d      = max_q;
        case (state_q)
            ST_IDLE: begin
                if (sumsValid) begin
                    shadow_d   = sumsIn;
                    best_idx_d = '0;
                    best_val_d = sumsIn[WIDTH-1:0];
                    if (NODES == 1) begin
                        scan_idx_d = '0;
                        class_d    = '0;
                        max_d      = sumsIn[WIDTH-1:0];
                    end else begin
                        scan_idx_d = CLASS_WIDTH'(1);
                    end
                end
            end
            ST_SCAN: begin
                if (scan_wins) begin
                    best_idx_d = scan_idx_q;
                    best_val_d = scan_node;
                end
                if (scan_last) begin
                    class_d = scan_wins ? scan_idx_q : best_idx_q;
                    max_d   = scan_wins ? scan_node  : best_val_q;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs are decoded from the registered state only.
    always_comb begin
        sumsReady   = (state_q == ST_IDLE);
        resultValid = (state_q == ST_HOLD);
        busy        = (state_q == ST_SCAN) || (state_q == ST_HOLD);
        classOut    = class_q;
        maxValueOut = max_q;
    end

endmodule

// File: tb/tb_softmax_argmax_reader.sv
// Testbench for softmax_argmax_reader.
//
// Two instances share one clock and clr: a 2-node reader and a 4-node reader,
// both with 6-bit sums. Vectors are directed and expected results are worked
// out by hand. Inputs change 1 time unit after the rising edge and outputs
// are sampled at the same point.

module tb_softmax_argmax_reader;

    logic        clk;
    logic        clr;

    logic [11:0] sums_in2;
    logic        sums_valid2;
    logic        sums_ready2;
    logic [0:0]  class_out2;
    logic [5:0]  max_out2;
    logic        result_valid2;
    logic        result_ready2;
    logic        busy2;

    logic [23:0] sums_in4;
    logic        sums_valid4;
    logic        sums_ready4;
    logic [1:0]  class_out4;
    logic [5:0]  max_out4;
    logic        result_valid4;
    logic        result_ready4;
    logic        busy4;

    int checks;
    int errors;
    int lat;

    softmax_argmax_reader #(.NODES(2), .WIDTH(6), .CLASS_WIDTH(1)) u_dut2 (
        .clk         (clk),
        .clr         (clr),
        .sumsIn      (sums_in2),
        .sumsValid   (sums_valid2),
        .sumsReady   (sums_ready2),
        .classOut    (class_out2),
        .maxValueOut (max_out2),
        .resultValid (result_valid2),
        .resultReady (result_ready2),
        .busy        (busy2)
    );

    softmax_argmax_reader #(.NODES(4), .WIDTH(6), .CLASS_WIDTH(2)) u_dut4 (
        .clk         (clk),
        .clr         (clr),
        .sumsIn      (sums_in4),
        .sumsValid   (sums_valid4),
        .sumsReady   (sums_ready4),
        .classOut    (class_out4),
        .maxValueOut (max_out4),
        .resultValid (result_valid4),
        .resultReady (result_ready4),
        .busy        (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // 4-node capture: pulse sumsValid, then count edges until resultValid.
    // With scramble set, sumsIn is overwritten every scan cycle.
    task automatic applyStimulus(input logic [23:0] vec, input bit scramble, output int edges);
        sums_in4    = vec;
        sums_valid4 = 1'b1;
        @(posedge clk); #1;
        sums_valid4 = 1'b0;
        edges = 0;
        while (result_valid4 !== 1'b1 && edges < 20) begin
            if (scramble) sums_in4 = {$urandom, $urandom} & 24'hFF_FFFF;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // 2-node capture, same shape as above.
    task automatic applyStimulus2(input logic [11:0] vec, output int edges);
        sums_in2    = vec;
        sums_valid2 = 1'b1;
        @(posedge clk); #1;
        sums_valid2 = 1'b0;
        edges = 0;
        while (result_valid2 !== 1'b1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic releaseResult4();
        result_ready4 = 1'b1;
        @(posedge clk); #1;
        result_ready4 = 1'b0;
    endtask

    task automatic releaseResult2();
        result_ready2 = 1'b1;
        @(posedge clk); #1;
        result_ready2 = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        clr           = 1'b1;
        sums_in2      = '0;
        sums_valid2   = 1'b0;
        result_ready2 = 1'b0;
        sums_in4      = '0;
        sums_valid4   = 1'b0;
        result_ready4 = 1'b0;

        // Reset state of both instances.
        @(posedge clk); #1;
        clr = 1'b0;
        checkOutput("rst2_ready", 32'(sums_ready2), 1);
        checkOutput("rst2_valid", 32'(result_valid2), 0);
        checkOutput("rst2_class", 32'(class_out2), 0);
        checkOutput("rst2_max", 32'(max_out2), 0);
        checkOutput("rst4_ready", 32'(sums_ready4), 1);
        checkOutput("rst4_busy", 32'(busy4), 0);

        // 2 nodes: node1=3 beats node0=-1, one edge of latency.
        applyStimulus2(12'b000011_111111, lat);
        checkOutput("n2_lat", 32'(lat), 1);
        checkOutput("n2_class", 32'(class_out2), 1);
        checkOutput("n2_max", 32'(max_out2), 3);
        checkOutput("n2_busy", 32'(busy2), 1);
        releaseResult2();
        checkOutput("n2_rel_ready", 32'(sums_ready2), 1);
        checkOutput("n2_rel_valid", 32'(result_valid2), 0);
        checkOutput("n2_retain_class", 32'(class_out2), 1);
        checkOutput("n2_retain_max", 32'(max_out2), 3);

        // 2 nodes: tie keeps node 0.
        applyStimulus2(12'b000101_000101, lat);
        checkOutput("n2_tie_lat", 32'(lat), 1);
        checkOutput("n2_tie_class", 32'(class_out2), 0);
        checkOutput("n2_tie_max", 32'(max_out2), 5);
        releaseResult2();

        // 4 nodes {-32,-1,-5,-32}: node 1 wins, three edges of latency.
        applyStimulus({6'b100000, 6'b111011, 6'b111111, 6'b100000}, 1'b0, lat);
        checkOutput("n4_lat", 32'(lat), 3);
        checkOutput("n4_class", 32'(class_out4), 1);
        checkOutput("n4_max", 32'(max_out4), 63);

        // Result is held while resultReady stays low; new sumsValid is ignored.
        sums_in4 = {6'd31, 6'd31, 6'd31, 6'd31};
        for (int i = 0; i < 5; i++) begin
            sums_valid4 = (i % 2 == 0);
            @(posedge clk); #1;
            checkOutput("hold_valid", 32'(result_valid4), 1);
            checkOutput("hold_ready", 32'(sums_ready4), 0);
            checkOutput("hold_class", 32'(class_out4), 1);
            checkOutput("hold_max", 32'(max_out4), 63);
        end
        sums_valid4 = 1'b0;
        releaseResult4();
        checkOutput("n4_rel_ready", 32'(sums_ready4), 1);
        checkOutput("n4_rel_valid", 32'(result_valid4), 0);
        checkOutput("n4_rel_busy", 32'(busy4), 0);
        @(posedge clk); #1;
        checkOutput("n4_no_dup", 32'(result_valid4), 0);
        checkOutput("n4_idle_class", 32'(class_out4), 1);

        // clr on the second scan cycle aborts, beating sumsValid and resultReady.
        sums_in4    = {6'd3, 6'd2, 6'd1, 6'd0};
        sums_valid4 = 1'b1;
        @(posedge clk); #1;
        sums_valid4 = 1'b0;
        @(posedge clk); #1;
        clr           = 1'b1;
        sums_valid4   = 1'b1;
        result_ready4 = 1'b1;
        @(posedge clk); #1;
        clr           = 1'b0;
        sums_valid4   = 1'b0;
        result_ready4 = 1'b0;
        checkOutput("abort_ready", 32'(sums_ready4), 1);
        checkOutput("abort_valid", 32'(result_valid4), 0);
        checkOutput("abort_class", 32'(class_out4), 0);
        checkOutput("abort_max", 32'(max_out4), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("abort_quiet", 32'(result_valid4), 0);
        end

        // Capture after abort: {5,7,7,-2}, tie between 1 and 2 keeps node 1.
        applyStimulus({6'b111110, 6'd7, 6'd7, 6'd5}, 1'b0, lat);
        checkOutput("post_lat", 32'(lat), 3);
        checkOutput("post_class", 32'(class_out4), 1);
        checkOutput("post_max", 32'(max_out4), 7);
        releaseResult4();

        // sumsIn scrambled during the scan; result follows the captured {1,2,3,4}.
        applyStimulus({6'd4, 6'd3, 6'd2, 6'd1}, 1'b1, lat);
        checkOutput("scr_lat", 32'(lat), 3);
        checkOutput("scr_class", 32'(class_out4), 3);
        checkOutput("scr_max", 32'(max_out4), 4);
        releaseResult4();

        // All nodes at the most negative value: node 0, value 100000.
        applyStimulus({4{6'b100000}}, 1'b0, lat);
        checkOutput("neg_class", 32'(class_out4), 0);
        checkOutput("neg_max", 32'(max_out4), 32);
        releaseResult4();

        // Largest positive value in node 2 against most negative neighbours.
        applyStimulus({6'b100000, 6'd31, 6'b111111, 6'b100000}, 1'b0, lat);
        checkOutput("pos_class", 32'(class_out4), 2);
        checkOutput("pos_max", 32'(max_out4), 31);
        releaseResult4();

        // clr while the 2-node reader holds a result drops that result.
        applyStimulus2(12'b111111_000010, lat);
        checkOutput("n2_h_class", 32'(class_out2), 0);
        checkOutput("n2_h_max", 32'(max_out2), 2);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checkOutput("n2_habort_valid", 32'(result_valid2), 0);
        checkOutput("n2_habort_ready", 32'(sums_ready2), 1);
        checkOutput("n2_habort_max", 32'(max_out2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
